coherence_bus_ctrl: RTL and testbench

Initiator side of the L1 snoop/coherence bus and the single shared path from the L1 caches to L2. It arbitrates round-robin among the per-core L1 miss requests and broadcasts one snoop for the winner to all other cores. After collecting their acknowledgements it forwards the request to L2 and routes the L2 response back to the requesting L1. It sits between the per-core `unified_cache` instances and `l2_cache` in `multicore_top`, replacing the shared L1→L2 wiring.

---
 rtl/coherence_bus_ctrl_if.sv | 47 ++++
 rtl/coherence_bus_ctrl.sv | 197 +++++++++++++++++++
 tb/tb_coherence_bus_ctrl.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/coherence_bus_ctrl_if.sv
// coherence_bus_ctrl_if
// Bundles the L1-side request/response, snoop broadcast and L2-side signals
// of the coherence bus controller.
//   master : controller view (drives snoop, L2 request, core response, status)
//   slave  : environment view (L1 requesters, snoop responders, L2)
// Per-core vectors pack core k at [k*WIDTH +: WIDTH].
interface coherence_bus_ctrl_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int NCORES     = 2,
  parameter int ID_WIDTH   = 2
);
  logic [NCORES-1:0]            core_req_valid;
  logic [NCORES-1:0]            core_req_wr;
  logic [NCORES*ADDR_WIDTH-1:0] core_req_addr;
  logic [NCORES*DATA_WIDTH-1:0] core_req_wdata;
  logic [NCORES-1:0]            core_resp_valid;
  logic [DATA_WIDTH-1:0]        core_resp_rdata;
  logic                         snoop_valid;
  logic [ADDR_WIDTH-1:0]        snoop_addr;
  logic [ID_WIDTH-1:0]          snoop_source_id;
  logic [NCORES-1:0]            snoop_ack_in;
  logic                         l2_req_valid;
  logic                         l2_req_wr;
  logic [ADDR_WIDTH-1:0]        l2_req_addr;
  logic [DATA_WIDTH-1:0]        l2_req_wdata;
  logic                         l2_resp_valid;
  logic [DATA_WIDTH-1:0]        l2_resp_rdata;
  logic                         busy;
  logic                         ack_timeout;

  modport master (
    input  core_req_valid, core_req_wr, core_req_addr, core_req_wdata,
           snoop_ack_in, l2_resp_valid, l2_resp_rdata,
    output core_resp_valid, core_resp_rdata, snoop_valid, snoop_addr,
           snoop_source_id, l2_req_valid, l2_req_wr, l2_req_addr,
           l2_req_wdata, busy, ack_timeout
  );

  modport slave (
    output core_req_valid, core_req_wr, core_req_addr, core_req_wdata,
           snoop_ack_in, l2_resp_valid, l2_resp_rdata,
    input  core_resp_valid, core_resp_rdata, snoop_valid, snoop_addr,
           snoop_source_id, l2_req_valid, l2_req_wr, l2_req_addr,
           l2_req_wdata, busy, ack_timeout
  );
endinterface

// File: rtl/coherence_bus_ctrl.sv
// coherence_bus_ctrl
// Round-robin arbiter for L1 miss requests. The winner's request is snooped
// to all other cores, acks are collected (with a timeout), the request is
// forwarded to L2 and the L2 response is returned to the requesting core.
// Ports:
//   clk   : clock, all logic on posedge
//   rst_n : synchronous active-low reset
//   bus   : coherence_bus_ctrl_if.master (requests, snoop, L2, status)
// All outputs are registered.
module coherence_bus_ctrl #(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int NCORES      = 2,
  parameter int ID_WIDTH    = 2,
  parameter int ACK_TIMEOUT = 16
) (
  input logic                  clk,
  input logic                  rst_n,
  coherence_bus_ctrl_if.master bus
);
  localparam int CNT_WIDTH = $clog2(ACK_TIMEOUT);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = CNT_WIDTH'(ACK_TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    SNOOP    = 3'd1,
    WAIT_ACK = 3'd2,
    L2_REQ   = 3'd3,
    L2_WAIT  = 3'd4,
    RESP     = 3'd5
  } state_t;

  state_t                  state_r;
  state_t                  state_next_s;
  logic [ID_WIDTH-1:0]     rr_ptr_r;
  logic [ID_WIDTH-1:0]     grant_r;
  logic                    wr_r;
  logic [ADDR_WIDTH-1:0]   addr_r;
  logic [DATA_WIDTH-1:0]   wdata_r;
  logic [NCORES-1:0]       ack_mask_r;
  logic [CNT_WIDTH-1:0]    cnt_r;
  logic                    snoop_valid_r;
  logic                    l2_req_valid_r;
  logic [NCORES-1:0]       core_resp_valid_r;
  logic [DATA_WIDTH-1:0]   core_resp_rdata_r;
  logic                    busy_r;
  logic                    ack_timeout_r;

  logic                    req_found_s;
  logic [ID_WIDTH-1:0]     req_id_s;
  logic                    req_wr_s;
  logic [ADDR_WIDTH-1:0]   req_addr_s;
  logic [DATA_WIDTH-1:0]   req_wdata_s;
  logic [NCORES-1:0]       src_mask_s;
  logic                    acks_all_s;
  logic                    timeout_hit_s;

  // Round-robin pick: cores at or above rr_ptr first, then the wrapped ones.
  always_comb begin
    req_found_s = 1'b0;
    req_id_s    = '0;
    req_wr_s    = 1'b0;
    req_addr_s  = '0;
    req_wdata_s = '0;
    for (int p = 0; p < 2; p++) begin
      for (int j = 0; j < NCORES; j++) begin
        if (!req_found_s && bus.core_req_valid[j] &&
            ((p == 0) ? (j >= int'(rr_ptr_r)) : (j < int'(rr_ptr_r)))) begin
          req_found_s = 1'b1;
          req_id_s    = ID_WIDTH'(j);
          req_wr_s    = bus.core_req_wr[j];
          req_addr_s  = bus.core_req_addr[j*ADDR_WIDTH +: ADDR_WIDTH];
          req_wdata_s = bus.core_req_wdata[j*DATA_WIDTH +: DATA_WIDTH];
        end else begin
          req_found_s = req_found_s;
        end
      end
    end
  end

  // The requester's own bit counts as acked; acks arriving this cycle count too.
  assign src_mask_s    = NCORES'(1'b1) << grant_r;
  assign acks_all_s    = &(ack_mask_r | bus.snoop_ack_in | src_mask_s);
  assign timeout_hit_s = (cnt_r == CNT_MAX);

  // Next-state logic of the transaction FSM.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (req_found_s) begin
          state_next_s = SNOOP;
        end else begin
          state_next_s = IDLE;
        end
      end
      SNOOP:    state_next_s = WAIT_ACK;
      WAIT_ACK: begin
        if (acks_all_s || timeout_hit_s) begin
          state_next_s = L2_REQ;
        end else begin
          state_next_s = WAIT_ACK;
        end
      end
      L2_REQ:   state_next_s = L2_WAIT;
      L2_WAIT: begin
        if (bus.l2_resp_valid) begin
          state_next_s = RESP;
        end else begin
          state_next_s = L2_WAIT;
        end
      end
      RESP:     state_next_s = IDLE;
      default:  state_next_s = IDLE;
    endcase
  end

  // State, latched request, ack/timeout bookkeeping and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r           <= IDLE;
      rr_ptr_r          <= '0;
      grant_r           <= '0;
      wr_r              <= 1'b0;
      addr_r            <= '0;
      wdata_r           <= '0;
      ack_mask_r        <= '0;
      cnt_r             <= '0;
      snoop_valid_r     <= 1'b0;
      l2_req_valid_r    <= 1'b0;
      core_resp_valid_r <= '0;
      core_resp_rdata_r <= '0;
      busy_r            <= 1'b0;
      ack_timeout_r     <= 1'b0;
    end else begin
      state_r        <= state_next_s;
      // Pulses are registered from the next state so they line up with it.
      snoop_valid_r  <= (state_next_s == SNOOP);
      l2_req_valid_r <= (state_next_s == L2_REQ);
      busy_r         <= (state_next_s != IDLE);
      core_resp_valid_r <= (state_next_s == RESP) ? src_mask_s : '0;
      // Raised one cycle early so the pulse sits in the final wait cycle,
      // immediately ahead of the L2 request.
      ack_timeout_r  <= (state_r == WAIT_ACK) && (state_next_s == WAIT_ACK) &&
                        ((cnt_r + CNT_WIDTH'(1)) == CNT_MAX);

      if ((state_r == IDLE) && req_found_s) begin
        grant_r <= req_id_s;
        wr_r    <= req_wr_s;
        addr_r  <= req_addr_s;
        wdata_r <= req_wdata_s;
      end else begin
        grant_r <= grant_r;
        wr_r    <= wr_r;
        addr_r  <= addr_r;
        wdata_r <= wdata_r;
      end

      // SNOOP restarts the mask and counter; requester acks never enter it.
      if (state_r == SNOOP) begin
        ack_mask_r <= bus.snoop_ack_in & ~src_mask_s;
        cnt_r      <= '0;
      end else if (state_r == WAIT_ACK) begin
        ack_mask_r <= ack_mask_r | (bus.snoop_ack_in & ~src_mask_s);
        cnt_r      <= (state_next_s == WAIT_ACK) ? (cnt_r + CNT_WIDTH'(1)) : cnt_r;
      end else begin
        ack_mask_r <= ack_mask_r;
        cnt_r      <= cnt_r;
      end

      if ((state_r == L2_WAIT) && bus.l2_resp_valid) begin
        core_resp_rdata_r <= bus.l2_resp_rdata;
      end else begin
        core_resp_rdata_r <= core_resp_rdata_r;
      end

      if (state_r == RESP) begin
        rr_ptr_r <= (grant_r == ID_WIDTH'(NCORES - 1)) ? '0 : (grant_r + ID_WIDTH'(1));
      end else begin
        rr_ptr_r <= rr_ptr_r;
      end
    end
  end

  // Snoop and L2 request fields come straight from the latched request.
  assign bus.snoop_valid     = snoop_valid_r;
  assign bus.snoop_addr      = addr_r;
  assign bus.snoop_source_id = grant_r;
  assign bus.l2_req_valid    = l2_req_valid_r;
  assign bus.l2_req_wr       = wr_r;
  assign bus.l2_req_addr     = addr_r;
  assign bus.l2_req_wdata    = wdata_r;
  assign bus.core_resp_valid = core_resp_valid_r;
  assign bus.core_resp_rdata = core_resp_rdata_r;
  assign bus.busy            = busy_r;
  assign bus.ack_timeout     = ack_timeout_r;
endmodule

// File: tb/tb_coherence_bus_ctrl.sv
// tb_coherence_bus_ctrl
// Directed self-checking bench for coherence_bus_ctrl (2 cores, ACK_TIMEOUT 16).
module tb_coherence_bus_ctrl;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int NC = 2;
  localparam int IW = 2;
  localparam int TO = 16;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_pass;
  int   n_snoop;
  int   n_l2req;
  int   n_resp;
  int   n_to;

  coherence_bus_ctrl_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NCORES(NC), .ID_WIDTH(IW)) bus_if ();

  coherence_bus_ctrl #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NCORES(NC), .ID_WIDTH(IW), .ACK_TIMEOUT(TO)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pulse counters sampled mid-cycle.
  initial begin
    n_snoop = 0; n_l2req = 0; n_resp = 0; n_to = 0;
  end
  always @(negedge clk) begin
    if (bus_if.snoop_valid === 1'b1) n_snoop++;
    if (bus_if.l2_req_valid === 1'b1) n_l2req++;
    if (bus_if.core_resp_valid !== '0) n_resp++;
    if (bus_if.ack_timeout === 1'b1) n_to++;
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end else begin
      n_pass++;
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus_if.core_req_valid = '0;
    bus_if.core_req_wr    = '0;
    bus_if.core_req_addr  = '0;
    bus_if.core_req_wdata = '0;
    bus_if.snoop_ack_in   = '0;
    bus_if.l2_resp_valid  = 1'b0;
    bus_if.l2_resp_rdata  = '0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    clear_inputs();
    step();
    step();
    rst_n = 1'b1;
  endtask

  task automatic check_idle_outputs(input string name);
    check_eq({name, "_busy"},    bus_if.busy, 0);
    check_eq({name, "_snoop_v"}, bus_if.snoop_valid, 0);
    check_eq({name, "_l2req_v"}, bus_if.l2_req_valid, 0);
    check_eq({name, "_resp_v"},  bus_if.core_resp_valid, 0);
    check_eq({name, "_ack_to"},  bus_if.ack_timeout, 0);
    check_eq({name, "_rdata"},   bus_if.core_resp_rdata, 0);
    check_eq({name, "_s_addr"},  bus_if.snoop_addr, 0);
    check_eq({name, "_l2_addr"}, bus_if.l2_req_addr, 0);
  endtask

  task automatic request(input int core, input logic wr, input logic [AW-1:0] addr,
                         input logic [DW-1:0] wdata);
    bus_if.core_req_wr[core]             = wr;
    bus_if.core_req_addr[core*AW +: AW]  = addr;
    bus_if.core_req_wdata[core*DW +: DW] = wdata;
    bus_if.core_req_valid[core]          = 1'b1;
  endtask

  // Called in the cycle the request is first sampled (cycle 0).
  // ack_mode: 0 = never ack, 1 = ack in cycle 2, 2 = ack in cycle 1 (snoop cycle).
  // l2_delay > 0 also drives a stray L2 response during the L2 request cycle.
  task automatic serve(input string name, input int core, input logic wr_e,
                       input logic [AW-1:0] addr_e, input logic [DW-1:0] wdata_e,
                       input logic [DW-1:0] rdata_l2, input int ack_mode, input int l2_delay);
    logic [NC-1:0] own;
    logic [NC-1:0] other;
    logic          prev_to;
    int            waited;
    int            snoop0, l2r0, resp0, to0;
    own = '0;
    own[core] = 1'b1;
    other = ~own;
    snoop0 = n_snoop; l2r0 = n_l2req; resp0 = n_resp; to0 = n_to;
    step(); // cycle 1: snoop
    check_eq({name, "_snoop_v"},  bus_if.snoop_valid, 1);
    check_eq({name, "_snoop_a"},  bus_if.snoop_addr, addr_e);
    check_eq({name, "_snoop_id"}, bus_if.snoop_source_id, core);
    check_eq({name, "_busy1"},    bus_if.busy, 1);
    if (ack_mode == 2) bus_if.snoop_ack_in = other;
    step(); // cycle 2: first ack-wait cycle
    bus_if.snoop_ack_in = '0;
    check_eq({name, "_snoop_pulse"}, bus_if.snoop_valid, 0);
    if (ack_mode == 1) bus_if.snoop_ack_in = other;
    prev_to = bus_if.ack_timeout;
    waited = 0;
    step(); // cycle 3
    bus_if.snoop_ack_in = '0;
    while (bus_if.l2_req_valid !== 1'b1 && waited < 40) begin
      prev_to = bus_if.ack_timeout;
      step();
      waited++;
    end
    check_eq({name, "_ack_wait"},    waited, (ack_mode == 0) ? (TO - 1) : 0);
    check_eq({name, "_to_before"},   prev_to, (ack_mode == 0) ? 1 : 0);
    check_eq({name, "_l2req_v"},     bus_if.l2_req_valid, 1);
    check_eq({name, "_l2req_wr"},    bus_if.l2_req_wr, wr_e);
    check_eq({name, "_l2req_addr"},  bus_if.l2_req_addr, addr_e);
    if (wr_e) check_eq({name, "_l2req_wdata"}, bus_if.l2_req_wdata, wdata_e);
    if (l2_delay > 0) begin
      bus_if.l2_resp_valid = 1'b1;
      bus_if.l2_resp_rdata = ~rdata_l2;
    end
    step(); // first L2 wait cycle
    bus_if.l2_resp_valid = 1'b0;
    check_eq({name, "_l2req_pulse"}, bus_if.l2_req_valid, 0);
    for (int k = 0; k < l2_delay; k++) step();
    check_eq({name, "_l2wait_busy"}, bus_if.busy, 1);
    check_eq({name, "_l2wait_resp"}, bus_if.core_resp_valid, 0);
    bus_if.l2_resp_valid = 1'b1;
    bus_if.l2_resp_rdata = rdata_l2;
    step(); // response cycle
    bus_if.l2_resp_valid = 1'b0;
    bus_if.l2_resp_rdata = '0;
    bus_if.core_req_valid[core] = 1'b0;
    check_eq({name, "_resp_v"},     bus_if.core_resp_valid, own);
    check_eq({name, "_resp_rdata"}, bus_if.core_resp_rdata, rdata_l2);
    check_eq({name, "_resp_busy"},  bus_if.busy, 1);
    step(); // back in idle
    check_eq({name, "_resp_pulse"}, bus_if.core_resp_valid, 0);
    check_eq({name, "_idle_busy"},  bus_if.busy, 0);
    check_eq({name, "_n_snoop"},    n_snoop - snoop0, 1);
    check_eq({name, "_n_l2req"},    n_l2req - l2r0, 1);
    check_eq({name, "_n_resp"},     n_resp - resp0, 1);
    check_eq({name, "_n_to"},       n_to - to0, (ack_mode == 0) ? 1 : 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  initial begin
    int snoop0, resp0;
    n_checks = 0;
    n_pass   = 0;
    do_reset();
    check_idle_outputs("rst");

    // Single read from core0, ack in cycle 2, L2 answers in cycle 4.
    request(0, 1'b0, 32'h0000_0100, 32'h0);
    serve("rd0", 0, 1'b0, 32'h0000_0100, 32'h0, 32'hDEAD_BEEF, 1, 0);

    // Simultaneous requests after reset: core0 first, then core1, then core0 again.
    do_reset();
    request(0, 1'b0, 32'h0000_1000, 32'h0);
    request(1, 1'b0, 32'h0000_1004, 32'h0);
    serve("sim_a0", 0, 1'b0, 32'h0000_1000, 32'h0, 32'h1111_0000, 1, 0);
    serve("sim_a1", 1, 1'b0, 32'h0000_1004, 32'h0, 32'h2222_0001, 1, 0);
    request(0, 1'b0, 32'h0000_1008, 32'h0);
    request(1, 1'b0, 32'h0000_100C, 32'h0);
    serve("sim_b0", 0, 1'b0, 32'h0000_1008, 32'h0, 32'h3333_0002, 1, 0);
    serve("sim_b1", 1, 1'b0, 32'h0000_100C, 32'h0, 32'h4444_0003, 1, 0);

    // Write from core1, ack only during the snoop cycle, slow L2 with a stray early strobe.
    request(1, 1'b1, 32'h0000_2040, 32'h0000_0055);
    serve("wr1", 1, 1'b1, 32'h0000_2040, 32'h0000_0055, 32'hA5A5_0001, 2, 2);

    // Core1 never acks: timeout path.
    request(0, 1'b0, 32'h0000_0500, 32'h0);
    serve("to0", 0, 1'b0, 32'h0000_0500, 32'h0, 32'hC0DE_0005, 0, 0);

    // Reset while waiting for L2, then a stray L2 response.
    request(0, 1'b0, 32'h0000_0300, 32'h0);
    step();
    step();
    bus_if.snoop_ack_in = 2'b10;
    step();
    bus_if.snoop_ack_in = '0;
    check_eq("mid_l2req_v", bus_if.l2_req_valid, 1);
    step();
    check_eq("mid_l2wait_busy", bus_if.busy, 1);
    rst_n = 1'b0;
    bus_if.core_req_valid = '0;
    step();
    step();
    check_idle_outputs("mid_rst");
    rst_n = 1'b1;
    snoop0 = n_snoop;
    resp0  = n_resp;
    bus_if.l2_resp_valid = 1'b1;
    bus_if.l2_resp_rdata = 32'h0BAD_0BAD;
    step();
    bus_if.l2_resp_valid = 1'b0;
    bus_if.l2_resp_rdata = '0;
    step();
    step();
    check_idle_outputs("stray");
    check_eq("stray_n_resp",  n_resp - resp0, 0);
    check_eq("stray_n_snoop", n_snoop - snoop0, 0);

    // Normal service after the disrupted transaction.
    request(1, 1'b0, 32'h0000_0400, 32'h0);
    serve("post1", 1, 1'b0, 32'h0000_0400, 32'h0, 32'h1234_5678, 1, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
